// File: rtl/assoc_read_cache_pkg.sv
// Shared types and address-split helpers for the set-associative read cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    LOOKUP,
    MREQ,
    FILL,
    UPDATE,
    RESPOND
  } state_t;

  function automatic int off_width(input int data_w, input int beats);
    return $clog2(beats * data_w / 8);
  endfunction

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_width(input int data_w, input int beats, input int sets);
    return data_w - off_width(data_w, beats) - idx_width(sets);
  endfunction

endpackage

// File: rtl/assoc_read_cache_if.sv
// Request/response bus used on both the processor side and the DRAM side.
interface assoc_read_cache_if #(
  parameter int DW = 64,
  parameter int TW = 13
);
  logic          reqcyc;
  logic          reqack;
  logic [DW-1:0] req;
  logic [TW-1:0] reqtag;
  logic          respcyc;
  logic          respack;
  logic [DW-1:0] resp;
  logic [TW-1:0] resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/assoc_read_cache_set_array.sv
// Valid/tag/data storage for all sets and ways, with parallel lookup,
// victim selection (lowest invalid way, else round-robin pointer) and flush.
module cache_set_array #(
  parameter int DW         = 64,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 32,
  parameter int LINE_BEATS = 8,
  parameter int TAGW       = 53,
  parameter int IDXW       = 5,
  parameter int WAYW       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic [IDXW-1:0]            i_idx,
  input  logic [TAGW-1:0]            i_tag,
  input  logic                       i_we,
  input  logic [LINE_BEATS*DW-1:0]   i_wr_line,
  output logic                       o_hit,
  output logic [WAYW-1:0]            o_hit_way,
  output logic [LINE_BEATS*DW-1:0]   o_hit_line,
  output logic [WAYW-1:0]            o_victim_way
);

  localparam int LW = LINE_BEATS * DW;

  logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
  logic [WAYW-1:0]     r_ptr   [NUM_SETS];
  logic [TAGW-1:0]     r_tag   [NUM_SETS][NUM_WAYS];
  logic [LW-1:0]       r_data  [NUM_SETS][NUM_WAYS];

  logic            w_has_invalid;
  logic [WAYW-1:0] w_invalid_way;

  // Downward scans so the lowest-numbered matching way wins.
  always_comb begin
    o_hit         = 1'b0;
    o_hit_way     = '0;
    o_hit_line    = '0;
    w_has_invalid = 1'b0;
    w_invalid_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (r_valid[i_idx][w] && (r_tag[i_idx][w] == i_tag)) begin
        o_hit      = 1'b1;
        o_hit_way  = WAYW'(w);
        o_hit_line = r_data[i_idx][w];
      end
      if (!r_valid[i_idx][w]) begin
        w_has_invalid = 1'b1;
        w_invalid_way = WAYW'(w);
      end
    end
    o_victim_way = w_has_invalid ? w_invalid_way : r_ptr[i_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (i_flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (i_we) begin
      r_valid[i_idx][o_victim_way] <= 1'b1;
      if (!w_has_invalid) begin
        r_ptr[i_idx] <= (r_ptr[i_idx] == WAYW'(NUM_WAYS - 1)) ? '0
                                                              : WAYW'(r_ptr[i_idx] + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_idx][o_victim_way]  <= i_tag;
      r_data[i_idx][o_victim_way] <= i_wr_line;
    end
  end

endmodule

// File: rtl/assoc_read_cache.sv
// N-way read-only line-fill cache. States: IDLE wait/flush | ACK accept pulse |
// LOOKUP tag compare | MREQ line request | FILL collect beats | UPDATE write way | RESPOND send line.
module assoc_read_cache
  import cache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NUM_WAYS       = 2,
  parameter int NUM_SETS       = 32,
  parameter int LINE_BEATS     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  assoc_read_cache_if.slave    p_bus,
  assoc_read_cache_if.master   m_bus,
  input  logic                 flush,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int OFFW  = off_width(BUS_DATA_WIDTH, LINE_BEATS);
  localparam int IDXW  = idx_width(NUM_SETS);
  localparam int TAGW  = tag_width(BUS_DATA_WIDTH, LINE_BEATS, NUM_SETS);
  localparam int LAW   = BUS_DATA_WIDTH - OFFW;
  localparam int WAYW  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BEATW = $clog2(LINE_BEATS);
  localparam int LW    = LINE_BEATS * BUS_DATA_WIDTH;
  localparam logic [BEATW-1:0] BEAT_LAST = BEATW'(LINE_BEATS - 1);

  state_t                   r_state, w_next;
  logic [LAW-1:0]           r_line_addr;
  logic [BUS_TAG_WIDTH-1:0] r_tag;
  logic [BEATW-1:0]         r_beat;
  logic [LW-1:0]            r_line;
  logic [31:0]              r_hit_cnt, r_miss_cnt;

  logic            w_hit;
  logic [WAYW-1:0] w_hit_way, w_victim_way;
  logic [LW-1:0]   w_hit_line;
  logic            w_flush_now, w_accept, w_we;

  assign w_flush_now = (r_state == IDLE) && flush;
  assign w_accept    = (r_state == IDLE) && !flush && p_bus.reqcyc;
  assign w_we        = (r_state == UPDATE);

  cache_set_array #(
    .DW         (BUS_DATA_WIDTH),
    .NUM_WAYS   (NUM_WAYS),
    .NUM_SETS   (NUM_SETS),
    .LINE_BEATS (LINE_BEATS),
    .TAGW       (TAGW),
    .IDXW       (IDXW),
    .WAYW       (WAYW)
  ) u_array (
    .clk          (clk),
    .rst_n        (reset),
    .i_flush      (w_flush_now),
    .i_idx        (r_line_addr[IDXW-1:0]),
    .i_tag        (r_line_addr[LAW-1:IDXW]),
    .i_we         (w_we),
    .i_wr_line    (r_line),
    .o_hit        (w_hit),
    .o_hit_way    (w_hit_way),
    .o_hit_line   (w_hit_line),
    .o_victim_way (w_victim_way)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    p_bus.reqack    = 1'b0;
    p_bus.respcyc   = 1'b0;
    m_bus.reqcyc    = 1'b0;
    m_bus.respack   = 1'b0;
    p_bus.resp      = r_line[r_beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
    p_bus.resptag   = r_tag;
    m_bus.req       = {r_line_addr, {OFFW{1'b0}}};
    m_bus.reqtag    = r_tag;
    case (r_state)
      IDLE:    if (w_accept) w_next = ACK;
      ACK: begin
        p_bus.reqack = 1'b1;
        w_next       = LOOKUP;
      end
      LOOKUP:  w_next = w_hit ? RESPOND : MREQ;
      MREQ: begin
        m_bus.reqcyc = 1'b1;
        if (m_bus.reqack) w_next = FILL;
      end
      FILL: begin
        m_bus.respack = m_bus.respcyc;
        if (m_bus.respcyc && (r_beat == BEAT_LAST)) w_next = UPDATE;
      end
      UPDATE:  w_next = RESPOND;
      RESPOND: begin
        p_bus.respcyc = 1'b1;
        if (p_bus.respack && (r_beat == BEAT_LAST)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_line_addr <= '0;
      r_tag       <= '0;
      r_beat      <= '0;
      r_line      <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_line_addr <= p_bus.req[BUS_DATA_WIDTH-1:OFFW];
          r_tag       <= p_bus.reqtag;
        end
        LOOKUP: begin
          r_beat <= '0;
          if (w_hit) begin
            r_line    <= w_hit_line;
            r_hit_cnt <= r_hit_cnt + 32'd1;
          end else begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
          end
        end
        FILL: if (m_bus.respcyc) begin
          r_line[r_beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= m_bus.resp;
          r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
        end
        UPDATE: r_beat <= '0;
        RESPOND: if (p_bus.respack) begin
          r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  logic w_unused;
  assign w_unused = ^{p_bus.req[OFFW-1:0], m_bus.resptag, w_hit_way};

endmodule

// File: tb/tb_assoc_read_cache.sv
// Scenario bench for assoc_read_cache: a deterministic DRAM model supplies lines and
// a queue of expected response beats is filled per request and drained as beats arrive.
module tb_assoc_read_cache;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;
  localparam int OFFB  = $clog2(BEATS * DW / 8);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hit_count, miss_count;

  assoc_read_cache_if #(.DW(DW), .TW(TW)) p_if ();
  assoc_read_cache_if #(.DW(DW), .TW(TW)) m_if ();

  assoc_read_cache #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .NUM_WAYS       (2),
    .NUM_SETS       (32),
    .LINE_BEATS     (BEATS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .p_bus      (p_if.slave),
    .m_bus      (m_if.master),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] sb_q[$];
  int            exp_hits = 0;
  int            exp_miss = 0;

  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] line, input int beat);
    return {line[31:0], 16'hC0DE, 8'h00, 8'(beat)};
  endfunction

  task automatic check_all_zero(input string name);
    logic [DW-1:0] resp_v, mreq_v;
    resp_v = p_if.resp;
    mreq_v = m_if.req;
    n_vec++;
    if ({p_if.reqack, p_if.respcyc, p_if.resptag, m_if.reqcyc, m_if.reqtag,
         m_if.respack, hit_count, miss_count} !== '0 || resp_v !== '0 || mreq_v !== '0) begin
      n_err++;
      $display("FAIL %s: outputs reqack=%b respcyc=%b resp=%h resptag=%h mreqcyc=%b mreq=%h mtag=%h mrespack=%b hits=%0d miss=%0d, want all 0",
               name, p_if.reqack, p_if.respcyc, resp_v, p_if.resptag, m_if.reqcyc, mreq_v,
               m_if.reqtag, m_if.respack, hit_count, miss_count);
    end
  endtask

  // Abort an in-flight fill with reset and verify nothing leaks out afterwards.
  task automatic abort_with_reset(input logic [DW-1:0] line, input int mbeat);
    reset = 1'b0;
    m_if.respcyc = 1'b1;
    m_if.resp = mem_word(line, mbeat);
    m_if.reqack = 1'b0;
    p_if.respack = 1'b0;
    p_if.reqcyc = 1'b0;
    #1;
    check_all_zero("reset_mid_fill_outputs");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (m_if.respack !== 1'b0) begin
      n_err++;
      $display("FAIL stale_beat_respack: got %b want 0", m_if.respack);
    end
    m_if.respcyc = 1'b0;
    sb_q.delete();
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic do_read(input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                         input bit exp_miss_f, input int stall_beat, input int stall_len,
                         input int abort_beat);
    logic [DW-1:0] line;
    int  cyc, mbeat, pbeat, stalled, first_resp;
    bit  saw_mreq, sending, done;
    line = addr & ~((64'd1 << OFFB) - 64'd1);
    for (int b = 0; b < BEATS; b++) sb_q.push_back(mem_word(line, b));
    if (exp_miss_f) exp_miss++;
    else exp_hits++;
    @(negedge clk);
    p_if.req = addr;
    p_if.reqtag = tag;
    p_if.reqcyc = 1'b1;
    cyc = 0; mbeat = 0; pbeat = 0; stalled = 0; first_resp = -1;
    saw_mreq = 1'b0; sending = 1'b0; done = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (p_if.reqcyc && p_if.reqack) p_if.reqcyc = 1'b0;

      if (sending) begin
        if (m_if.respcyc && m_if.respack) mbeat++;
        if (abort_beat >= 0 && mbeat == abort_beat) begin
          abort_with_reset(line, mbeat);
          return;
        end
        if (mbeat < BEATS) begin
          m_if.respcyc = (cyc % 3 != 0);
          m_if.resp = mem_word(line, mbeat);
        end else begin
          m_if.respcyc = 1'b0;
          sending = 1'b0;
        end
      end
      if (m_if.reqack) begin
        m_if.reqack = 1'b0;
        sending = 1'b1;
        m_if.respcyc = 1'b1;
        m_if.resp = mem_word(line, 0);
      end else if (m_if.reqcyc && !saw_mreq) begin
        saw_mreq = 1'b1;
        n_vec++;
        if (m_if.req !== line || m_if.reqtag !== tag) begin
          n_err++;
          $display("FAIL mreq_addr: got %h/%h want %h/%h", m_if.req, m_if.reqtag, line, tag);
        end
        m_if.reqack = 1'b1;
      end

      if (p_if.respcyc) begin
        if (pbeat >= BEATS) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_beat: respcyc still %b after %0d beats, want 0", p_if.respcyc, pbeat);
          p_if.respack = 1'b0;
          done = 1'b1;
        end else begin
          if (first_resp < 0) begin
            first_resp = cyc;
            if (!exp_miss_f) begin
              n_vec++;
              if (first_resp != 3) begin
                n_err++;
                $display("FAIL hit_latency: got %0d cycles want 3", first_resp);
              end
            end
          end
          n_vec++;
          if (p_if.resp !== sb_q[0] || p_if.resptag !== tag) begin
            n_err++;
            $display("FAIL resp_beat%0d: got %h/%h want %h/%h", pbeat, p_if.resp, p_if.resptag, sb_q[0], tag);
          end
          if (pbeat == stall_beat && stalled < stall_len) begin
            p_if.respack = 1'b0;
            stalled++;
          end else begin
            p_if.respack = 1'b1;
            void'(sb_q.pop_front());
            pbeat++;
          end
        end
      end else begin
        p_if.respack = 1'b0;
        if (pbeat == BEATS) done = 1'b1;
      end
    end
    p_if.reqcyc = 1'b0;
    p_if.respack = 1'b0;
    m_if.respcyc = 1'b0;
    m_if.reqack = 1'b0;

    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL read_timeout: addr %h got %0d beats want %0d", addr, pbeat, BEATS);
      sb_q.delete();
    end
    n_vec++;
    if (saw_mreq !== exp_miss_f) begin
      n_err++;
      $display("FAIL mreq_seen: addr %h got %b want %b", addr, saw_mreq, exp_miss_f);
    end
    n_vec++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_miss)) begin
      n_err++;
      $display("FAIL counters: got hit=%0d miss=%0d want hit=%0d miss=%0d",
               hit_count, miss_count, exp_hits, exp_miss);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    do_read(64'h1000, 13'h5, 1'b1, -1, 0, -1);
  endtask

  task automatic test_hit();
    do_read(64'h1008, 13'h6, 1'b0, -1, 0, -1);
  endtask

  task automatic test_eviction();
    do_read(64'h1000, 13'h11, 1'b0, -1, 0, -1);
    do_read(64'h1800, 13'h12, 1'b1, -1, 0, -1);
    do_read(64'h2000, 13'h13, 1'b1, -1, 0, -1);
    do_read(64'h1800, 13'h14, 1'b0, -1, 0, -1);
    do_read(64'h1000, 13'h15, 1'b1, -1, 0, -1);
    do_read(64'h1040, 13'h16, 1'b1, -1, 0, -1);
    do_read(64'h1078, 13'h17, 1'b0, -1, 0, -1);
  endtask

  task automatic test_backpressure();
    do_read(64'h1008, 13'h1ABC, 1'b0, 3, 5, -1);
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1;
    p_if.req = 64'h1000;
    p_if.reqtag = 13'h7;
    p_if.reqcyc = 1'b1;
    @(negedge clk);
    n_vec++;
    if (p_if.reqack !== 1'b0) begin
      n_err++;
      $display("FAIL flush_priority: reqack got %b want 0", p_if.reqack);
    end
    flush = 1'b0;
    p_if.reqcyc = 1'b0;
    do_read(64'h1000, 13'h7, 1'b1, -1, 0, -1);
    do_read(64'h1800, 13'h8, 1'b1, -1, 0, -1);
  endtask

  task automatic test_reset_mid_fill();
    do_read(64'h1000, 13'h9, 1'b0, -1, 0, -1);
    do_read(64'h4000, 13'hA, 1'b1, -1, 0, 4);
    do_read(64'h1000, 13'hB, 1'b1, -1, 0, -1);
    do_read(64'h1000, 13'hC, 1'b0, -1, 0, -1);
  endtask

  initial begin
    p_if.reqcyc = 1'b0;
    p_if.req = '0;
    p_if.reqtag = '0;
    p_if.respack = 1'b0;
    m_if.reqack = 1'b0;
    m_if.respcyc = 1'b0;
    m_if.resp = '0;
    m_if.resptag = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_eviction();
    test_backpressure();
    test_flush();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/assoc_read_cache.md
Name: assoc_read_cache

Overview:
- Parametrised N-way set-associative, read-only, line-fill cache between the processor-side bus and the DRAM-side bus.
- Generalises the direct-mapped cache: configurable ways, sets, line length, data and tag widths.
- Adds per-set round-robin replacement, a single-cycle flush, and hit/miss counters.
- Each processor request is answered with a full line, beat 0 first.

Parameters:
- BUS_DATA_WIDTH, 64: bus data/address width in bits; also the address width.
- BUS_TAG_WIDTH, 13: request/response tag width.
- NUM_WAYS, 2: associativity; power of 2, at least 1 (1 = direct-mapped).
- NUM_SETS, 32: sets; power of 2, at least 2.
- LINE_BEATS, 8: bus beats per line; power of 2, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; reset==0 resets the block.
- p_bus_reqcyc  in  1  processor read request valid.
- p_bus_reqack  out  1  request accepted (one-cycle pulse).
- p_bus_req  in  BUS_DATA_WIDTH  byte address.
- p_bus_reqtag  in  BUS_TAG_WIDTH  request tag.
- p_bus_respcyc  out  1  response beat valid.
- p_bus_respack  in  1  processor takes the beat.
- p_bus_resp  out  BUS_DATA_WIDTH  response beat data.
- p_bus_resptag  out  BUS_TAG_WIDTH  captured request tag.
- m_bus_reqcyc  out  1  memory line read request.
- m_bus_reqack  in  1  memory accepted the request.
- m_bus_req  out  BUS_DATA_WIDTH  line-aligned address.
- m_bus_reqtag  out  BUS_TAG_WIDTH  captured request tag.
- m_bus_respcyc  in  1  memory beat valid.
- m_bus_respack  out  1  beat taken.
- m_bus_resp  in  BUS_DATA_WIDTH  memory beat data.
- m_bus_resptag  in  BUS_TAG_WIDTH  ignored.
- flush  in  1  invalidate all lines.
- hit_count  out  32  lookup hits, wraps at 2^32.
- miss_count  out  32  lookup misses, wraps at 2^32.

Behaviour:
- Address split:
  - OFF = log2(LINE_BEATS*BUS_DATA_WIDTH/8)
  - IDX = log2(NUM_SETS)
  - tag = addr[W-1:OFF+IDX], index = addr[OFF+IDX-1:OFF]
  - Offset bits are ignored for lookup; m_bus_req = addr with the OFF LSBs zeroed.
- Reset (reset==0, asynchronous):
  - state=IDLE; all valid bits, round-robin pointers and counters = 0.
  - Every output = 0.
  - In-flight fill is abandoned; later memory beats get no respack.
- State machine:
  - IDLE: flush has priority. If flush=1, clear all valid bits and pointers at the next edge and stay in IDLE; reqcyc waits. Else if reqcyc=1, capture addr/tag and go to ACK.
  - ACK: p_bus_reqack=1 for exactly one cycle, then LOOKUP.
  - LOOKUP: compare all ways in parallel. On hit, latch that way's line, increment hit_count, go to RESPOND. On miss, increment miss_count, go to MREQ.
  - MREQ: hold m_bus_reqcyc=1 with stable req/reqtag until m_bus_reqack=1 is sampled; then go to FILL with beat=0.
  - FILL: m_bus_respack = m_bus_respcyc (combinational, same cycle). Each accepted beat is written to fill-buffer slot beat. After slot LINE_BEATS-1, go to UPDATE.
  - UPDATE: write {valid=1, tag, line} into the victim way; the line is also the response line. Advance this set's round-robin pointer only when the victim came from the pointer. Go to RESPOND with beat=0.
  - RESPOND: p_bus_respcyc=1, p_bus_resp = line beat[beat], resptag = captured tag, all held stable until p_bus_respack=1. A beat transfers on any cycle with respcyc&&respack; respcyc may stay high across consecutive beats. After beat LINE_BEATS-1 transfers, respcyc drops next cycle; go to IDLE.
- Victim: lowest-numbered invalid way in the set; otherwise the set's round-robin pointer, which wraps NUM_WAYS-1 -> 0.
- Hit latency: reqcyc sampled at cycle 0 -> reqack at cycle 1 -> LOOKUP at cycle 2 -> first respcyc at cycle 3.
- Miss penalty adds MREQ, FILL and UPDATE cycles.
- flush outside IDLE has no effect until the FSM returns to IDLE, if still asserted.
- Exactly one processor request is outstanding; reqcyc is ignored outside IDLE.
- No duplicate tags within a set: a fill follows only a miss.

Decomposition:
- Package cache_pkg: state enum (IDLE, ACK, LOOKUP, MREQ, FILL, UPDATE, RESPOND) and the OFF/IDX/tag width localparam functions.
- Sub-module cache_set_array:
  - valid, tag and data storage plus per-set round-robin pointers.
  - Combinational read of all ways at an index; hit/way/victim outputs.
  - Write port and flush-clear.
- The top level holds the FSM, capture registers, fill buffer and counters.

Test Plan (defaults: 64-byte line, index = addr[10:6]):
- Cold read 0x1000, tag 0x5 -> one m_bus_req at 0x1000; 8 memory beats D0..D7 -> p_bus_resp D0..D7 in order, resptag 0x5; miss_count=1.
- Re-read 0x1008 -> hit, no m_bus_reqcyc, first respcyc 3 cycles after reqcyc, data D0..D7; hit_count=1.
- Reads 0x1000, 0x1800, 0x2000 (same set 0) -> the third evicts way 0 (0x1000); re-read 0x1800 hits, 0x1000 misses.
- Hold p_bus_respack low 5 cycles on beat 3 -> resp stays D3, no beat skipped or duplicated.
- flush pulse in IDLE with reqcyc high the same cycle -> flush wins; the following read 0x1000 misses.
- reset=0 during FILL beat 4 -> all outputs 0 immediately; after release, 0x1000 misses (no partial line valid).
